apb_multi_slave_bridge: RTL and testbench
=========================================

Name: apb_multi_slave_bridge

Overview:
Parametrised APB requester bridge, the next generation of the single-slave 8-bit master/slave pair. It takes one request at a time from a valid/ready command port and decodes the address to one of NUM_SLAVES slaves. It runs the APB SETUP/ACCESS sequence with unlimited wait states and returns read data plus an error flag. It adds behaviour the earlier bridge lacks: address decode errors, slave error forwarding, and a PREADY timeout abort. It sits between the CPU-side command logic and the APB slave fabric.

Parameters:
ADDR_W, 8, address width of req_addr and PADDR
DATA_W, 8, data width of all data buses
NUM_SLAVES, 4, number of APB slaves (1..16)
TIMEOUT, 16, maximum ACCESS cycles with PREADY low before abort; 0 disables the timeout

Ports:
PCLK  in  1  clock, all logic on rising edge
PRESET  in  1  reset; one clock; reset is synchronous and active-high
req_valid  in  1  command valid
req_ready  out  1  bridge can accept a command
req_write  in  1  1=write, 0=read
req_addr  in  ADDR_W  command address
req_wdata  in  DATA_W  write data
rsp_valid  out  1  one-cycle response pulse, no back-pressure
rsp_rdata  out  DATA_W  read data; 0 for writes and errors
rsp_err  out  1  response error (slave error, decode miss or timeout)
PADDR  out  ADDR_W  APB address
PWDATA  out  DATA_W  APB write data
PWRITE  out  1  APB direction
PSEL  out  NUM_SLAVES  one-hot slave select
PENABLE  out  1  APB enable
PRDATA  in  NUM_SLAVES*DATA_W  slave read data, flattened, slave i at [i*DATA_W +: DATA_W]
PREADY  in  NUM_SLAVES  per-slave ready
PSLVERR  in  NUM_SLAVES  per-slave error

Behaviour:
- Reset: state IDLE, all outputs 0, wait counter 0. req_ready is 0 while PRESET is high. Reset mid-transfer drops PSEL/PENABLE at that edge and emits no response.
- Decode: SEL_W = clog2(NUM_SLAVES), and idx = req_addr[ADDR_W-1 -: SEL_W]. If NUM_SLAVES=1, idx=0 always. If idx >= NUM_SLAVES, the request is a decode miss.
- FSM states: IDLE, SETUP, ACCESS, DERR.
- IDLE: req_ready=1. On req_valid at edge T, latch addr/wdata/write/idx into PADDR/PWDATA/PWRITE.
  - Valid decode: go to SETUP and assert PSEL[idx] with PENABLE=0 in cycle T+1.
  - Decode miss: go to DERR, with PSEL all 0.
- SETUP: go to ACCESS unconditionally. PENABLE=1 from cycle T+2.
- ACCESS: sample PREADY[idx] on each edge.
  - PREADY high: register rsp_rdata = (read ? PRDATA[idx] : 0), rsp_err = PSLVERR[idx], and rsp_valid=1. Drop PSEL/PENABLE and go to IDLE.
  - Zero wait states: rsp_valid is high in cycle T+3.
- Timeout: the counter increments on each ACCESS cycle with PREADY low. If it reaches TIMEOUT at an edge with PREADY still low, abort: PSEL/PENABLE drop, rsp_valid=1, rsp_err=1, rsp_rdata=0, go to IDLE. The counter clears on leaving ACCESS.
- DERR: one cycle, then go to IDLE with rsp_valid=1, rsp_err=1, rsp_rdata=0 in cycle T+2. No APB activity occurs.
- rsp_valid is a one-cycle pulse. rsp_rdata/rsp_err hold until the next response.
- Back-to-back: req_ready is high in the cycle rsp_valid is high, so the next request may be accepted there.
- PADDR/PWDATA/PWRITE are stable from SETUP through the end of ACCESS and hold their last values in IDLE.
- PSEL is never multi-hot. PENABLE is never high without PSEL.
- Non-selected slaves' PREADY/PSLVERR/PRDATA are ignored.

Decomposition:
- Package apb_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, DERR)
  - clog2-based SEL_W helper function
  - timeout counter width constant (clog2(TIMEOUT+1))
- One sub-module: apb_addr_decoder, combinational, mapping addr -> one-hot sel, idx, miss. It is instanced once and reusable by the slave-side fabric.

Test Plan:
1. Zero-wait write: req addr 0x45, data 0xA5, write, default params -> PSEL=4'b0010 at T+1, PENABLE at T+2, PREADY[1]=1 -> rsp_valid T+3, rsp_err=0, rsp_rdata=0.
2. Wait-state read: addr 0xC2, read; PREADY[3] low 3 cycles, then high with PRDATA[3]=0x5A -> PENABLE high 4 cycles, rsp_valid T+6, rsp_rdata=0x5A, PADDR stable at 0xC2 throughout.
3. Timeout: TIMEOUT=16, addr 0x10, PREADY[0] stuck low -> PSEL[0] drops after 16 ACCESS cycles, rsp_err=1, rsp_rdata=0; the next request is accepted normally.
4. Decode miss: NUM_SLAVES=3, addr 0xC0 -> PSEL stays 0 throughout, rsp_valid T+2 with rsp_err=1.
5. Slave error: addr 0x80 read, PREADY[2]=1 with PSLVERR[2]=1 and PRDATA[2]=0x33 -> rsp_err=1, rsp_rdata=0x33.
6. Reset mid-ACCESS, then back-to-back:
   - PRESET=1 during ACCESS wait -> PSEL/PENABLE/rsp_valid 0 at the next edge, no response.
   - After release, two requests with req_valid held -> second accepted in the rsp_valid cycle of the first.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared types and sizing helpers for the multi-slave APB requester bridge.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DERR   = 2'd3
    } apb_state_e;

    // Number of top address bits used to pick a slave; zero for a single slave.
    function automatic int unsigned sel_w(input int unsigned num_slaves);
        return (num_slaves <= 1) ? 0 : $clog2(num_slaves);
    endfunction

    // Slave index register width, never narrower than one bit.
    function automatic int unsigned idx_w(input int unsigned num_slaves);
        return (sel_w(num_slaves) == 0) ? 1 : sel_w(num_slaves);
    endfunction

    // Wait-state counter width, able to hold the value TIMEOUT.
    function automatic int unsigned cnt_w(input int unsigned timeout);
        return (timeout == 0) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/apb_addr_decoder.sv
// Combinational slave decode: top address bits select one slave, indices past
// the last slave are reported as a miss with no select asserted.
module apb_addr_decoder
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned NUM_SLAVES = 4,
    localparam int unsigned IDX_W     = idx_w(NUM_SLAVES)
) (
    input  logic [ADDR_W-1:0]     addr,
    output logic [NUM_SLAVES-1:0] sel_c,
    output logic [IDX_W-1:0]      idx_c,
    output logic                  miss_c
);

    localparam int unsigned SEL_W = sel_w(NUM_SLAVES);

    // Low address bits belong to the slave's own register map.
    logic unused_addr;
    assign unused_addr = ^addr;

    generate
        if (SEL_W == 0) begin : g_single
            assign idx_c  = '0;
            assign miss_c = 1'b0;
            assign sel_c  = '1;
        end else begin : g_multi
            logic [SEL_W-1:0] field;
            assign field  = addr[ADDR_W-1 -: SEL_W];
            assign idx_c  = IDX_W'(field);
            assign miss_c = (32'(field) >= 32'(NUM_SLAVES));
            assign sel_c  = miss_c ? '0 : (NUM_SLAVES'(1) << field);
        end
    endgenerate

endmodule

// File: rtl/apb_multi_slave_bridge.sv
// APB requester bridge: one command at a time from a valid/ready port, decoded
// to one of NUM_SLAVES slaves, with decode-miss, slave-error and timeout reporting.
module apb_multi_slave_bridge
    import apb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned TIMEOUT    = 16
) (
    input  logic                         PCLK,
    input  logic                         PRESET,
    input  logic                         req_valid,
    output logic                         req_ready,
    input  logic                         req_write,
    input  logic [ADDR_W-1:0]            req_addr,
    input  logic [DATA_W-1:0]            req_wdata,
    output logic                         rsp_valid,
    output logic [DATA_W-1:0]            rsp_rdata,
    output logic                         rsp_err,
    output logic [ADDR_W-1:0]            PADDR,
    output logic [DATA_W-1:0]            PWDATA,
    output logic                         PWRITE,
    output logic [NUM_SLAVES-1:0]        PSEL,
    output logic                         PENABLE,
    input  logic [NUM_SLAVES*DATA_W-1:0] PRDATA,
    input  logic [NUM_SLAVES-1:0]        PREADY,
    input  logic [NUM_SLAVES-1:0]        PSLVERR
);

    localparam int unsigned IDX_W   = idx_w(NUM_SLAVES);
    localparam int unsigned CNT_W   = cnt_w(TIMEOUT);
    localparam int unsigned CNT_MAX = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

    apb_state_e state_q, state_d;

    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_W-1:0]     paddr_d;
    logic [DATA_W-1:0]     pwdata_d;
    logic                  pwrite_d;
    logic [NUM_SLAVES-1:0] psel_d;
    logic                  penable_d;
    logic                  rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_d;
    logic                  rsp_err_d;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic [IDX_W-1:0]      dec_idx;
    logic                  dec_miss;

    logic                  pready_sel;
    logic                  pslverr_sel;
    logic [DATA_W-1:0]     prdata_sel;

    apb_addr_decoder #(
        .ADDR_W     (ADDR_W),
        .NUM_SLAVES (NUM_SLAVES)
    ) u_dec (
        .addr   (req_addr),
        .sel_c  (dec_sel),
        .idx_c  (dec_idx),
        .miss_c (dec_miss)
    );

    assign req_ready = (state_q == IDLE) && !PRESET;

    // Only the latched slave's return signals are ever looked at.
    always_comb begin
        pready_sel  = 1'b0;
        pslverr_sel = 1'b0;
        prdata_sel  = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (idx_q == IDX_W'(i)) begin
                pready_sel  = PREADY[i];
                pslverr_sel = PSLVERR[i];
                prdata_sel  = PRDATA[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        paddr_d     = PADDR;
        pwdata_d    = PWDATA;
        pwrite_d    = PWRITE;
        psel_d      = PSEL;
        penable_d   = PENABLE;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    paddr_d  = req_addr;
                    pwdata_d = req_wdata;
                    pwrite_d = req_write;
                    idx_d    = dec_idx;
                    if (dec_miss) begin
                        state_d = DERR;
                        psel_d  = '0;
                    end else begin
                        state_d = SETUP;
                        psel_d  = dec_sel;
                    end
                end
            end
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (pready_sel) begin
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = PWRITE ? '0 : prdata_sel;
                    rsp_err_d   = pslverr_sel;
                end else if ((TIMEOUT != 0) && (cnt_q == CNT_W'(CNT_MAX))) begin
                    // Slave stalled too long: abandon the transfer and report it.
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                end else if (TIMEOUT != 0) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DERR: begin
                state_d     = IDLE;
                rsp_valid_d = 1'b1;
                rsp_rdata_d = '0;
                rsp_err_d   = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            PADDR     <= '0;
            PWDATA    <= '0;
            PWRITE    <= 1'b0;
            PSEL      <= '0;
            PENABLE   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            PADDR     <= paddr_d;
            PWDATA    <= pwdata_d;
            PWRITE    <= pwrite_d;
            PSEL      <= psel_d;
            PENABLE   <= penable_d;
            rsp_valid <= rsp_valid_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

endmodule

// File: tb/tb_apb_multi_slave_bridge.sv
// Bench for apb_multi_slave_bridge: a 4-slave instance for the main scenarios and
// a 3-slave instance for decode misses, with response scoreboards on both.
module tb_apb_multi_slave_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        req_valid, req_ready, req_write;
    logic [7:0]  req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [7:0]  rsp_rdata;
    logic [7:0]  paddr, pwdata;
    logic        pwrite, penable;
    logic [3:0]  psel, pready, pslverr;
    logic [31:0] prdata;

    logic        r3_valid, r3_ready, r3_write;
    logic [7:0]  r3_addr, r3_wdata;
    logic        s3_valid, s3_err;
    logic [7:0]  s3_rdata;
    logic [7:0]  paddr3, pwdata3;
    logic        pwrite3, penable3;
    logic [2:0]  psel3, pready3, pslverr3;
    logic [23:0] prdata3;

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] sb[$];
    logic [8:0] sb3[$];
    logic [8:0] exp_a, exp_b;

    apb_multi_slave_bridge #(.ADDR_W(8), .DATA_W(8), .NUM_SLAVES(4), .TIMEOUT(16)) dut (
        .PCLK(clk), .PRESET(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .PADDR(paddr), .PWDATA(pwdata), .PWRITE(pwrite), .PSEL(psel), .PENABLE(penable),
        .PRDATA(prdata), .PREADY(pready), .PSLVERR(pslverr)
    );

    apb_multi_slave_bridge #(.ADDR_W(8), .DATA_W(8), .NUM_SLAVES(3), .TIMEOUT(16)) dut3 (
        .PCLK(clk), .PRESET(rst),
        .req_valid(r3_valid), .req_ready(r3_ready), .req_write(r3_write),
        .req_addr(r3_addr), .req_wdata(r3_wdata),
        .rsp_valid(s3_valid), .rsp_rdata(s3_rdata), .rsp_err(s3_err),
        .PADDR(paddr3), .PWDATA(pwdata3), .PWRITE(pwrite3), .PSEL(psel3), .PENABLE(penable3),
        .PRDATA(prdata3), .PREADY(pready3), .PSLVERR(pslverr3)
    );

    // Response scoreboards: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            n_checks++;
            if (sb.size() == 0) begin
                $display("FAIL rsp_unexpected got err=%b rdata=%h with nothing expected", rsp_err, rsp_rdata);
            end else begin
                exp_a = sb.pop_front();
                if ({rsp_err, rsp_rdata} !== exp_a)
                    $display("FAIL rsp_scoreboard got err=%b rdata=%h exp err=%b rdata=%h",
                             rsp_err, rsp_rdata, exp_a[8], exp_a[7:0]);
                else n_pass++;
            end
        end
        if (s3_valid === 1'b1) begin
            n_checks++;
            if (sb3.size() == 0) begin
                $display("FAIL rsp3_unexpected got err=%b rdata=%h with nothing expected", s3_err, s3_rdata);
            end else begin
                exp_b = sb3.pop_front();
                if ({s3_err, s3_rdata} !== exp_b)
                    $display("FAIL rsp3_scoreboard got err=%b rdata=%h exp err=%b rdata=%h",
                             s3_err, s3_rdata, exp_b[8], exp_b[7:0]);
                else n_pass++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Present a command and return in the cycle after the accepting edge.
    task automatic send(input logic w, input logic [7:0] a, input logic [7:0] d);
        int n = 0;
        req_write = w; req_addr = a; req_wdata = d; req_valid = 1'b1;
        while (req_ready !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL send_accept req_ready got=%b exp=1", req_ready);
        else n_pass++;
        tick();
        req_valid = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        pready = '0; pslverr = '0; prdata = '0;
        r3_valid = 1'b0; r3_write = 1'b0; r3_addr = '0; r3_wdata = '0;
        pready3 = '0; pslverr3 = '0; prdata3 = '0;
        repeat (3) tick();
        n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready got=%b exp=0", req_ready); else n_pass++;
        n_checks++; if ({psel, penable, rsp_valid} !== 6'b0) $display("FAIL reset_apb got psel=%b en=%b vld=%b exp 0", psel, penable, rsp_valid); else n_pass++;
        n_checks++; if ({rsp_err, rsp_rdata, paddr, pwdata, pwrite} !== 26'b0) $display("FAIL reset_regs got err=%b rdata=%h paddr=%h pwdata=%h pwrite=%b exp 0", rsp_err, rsp_rdata, paddr, pwdata, pwrite); else n_pass++;
        rst = 1'b0;
        tick();
        n_checks++; if (req_ready !== 1'b1 || r3_ready !== 1'b1) $display("FAIL reset_release_ready got=%b/%b exp=1/1", req_ready, r3_ready); else n_pass++;
    endtask

    task automatic test_zero_wait_write;
        pready = 4'b0010; pslverr = 4'b1101; prdata = 32'hEEEE_EEEE;
        sb.push_back({1'b0, 8'h00});
        send(1'b1, 8'h45, 8'hA5);
        n_checks++; if ({psel, penable} !== 5'b0010_0) $display("FAIL zw_setup got psel=%b en=%b exp psel=0010 en=0", psel, penable); else n_pass++;
        n_checks++; if ({paddr, pwdata, pwrite} !== {8'h45, 8'hA5, 1'b1}) $display("FAIL zw_bus got paddr=%h pwdata=%h pwrite=%b exp 45/a5/1", paddr, pwdata, pwrite); else n_pass++;
        tick();
        n_checks++; if ({psel, penable, rsp_valid} !== 6'b0010_1_0) $display("FAIL zw_access got psel=%b en=%b vld=%b exp 0010/1/0", psel, penable, rsp_valid); else n_pass++;
        tick();
        n_checks++; if ({rsp_valid, req_ready, psel, penable} !== 7'b1_1_0000_0) $display("FAIL zw_rsp got vld=%b rdy=%b psel=%b en=%b exp 1/1/0000/0", rsp_valid, req_ready, psel, penable); else n_pass++;
        tick();
        n_checks++; if (rsp_valid !== 1'b0) $display("FAIL zw_pulse got vld=%b exp=0", rsp_valid); else n_pass++;
    endtask

    task automatic test_wait_state_read;
        int en_cycles = 0;
        logic stable = 1'b1;
        logic early = 1'b0;
        pready = 4'b0111; pslverr = 4'b0000; prdata = 32'h1122_3344;
        sb.push_back({1'b0, 8'h5A});
        send(1'b0, 8'hC2, 8'h99);
        n_checks++; if ({psel, penable} !== 5'b1000_0) $display("FAIL ws_setup got psel=%b en=%b exp 1000/0", psel, penable); else n_pass++;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (penable === 1'b1) en_cycles++;
            if (paddr !== 8'hC2 || pwrite !== 1'b0) stable = 1'b0;
            if (rsp_valid === 1'b1) early = 1'b1;
            if (k == 3) begin
                pready = 4'b1000;
                prdata = 32'h5A00_0000;
            end
        end
        tick();
        n_checks++; if (rsp_valid !== 1'b1 || early !== 1'b0) $display("FAIL ws_rsp_time got vld=%b early=%b exp 1/0", rsp_valid, early); else n_pass++;
        n_checks++; if (en_cycles !== 4) $display("FAIL ws_penable_cycles got=%0d exp=4", en_cycles); else n_pass++;
        n_checks++; if (stable !== 1'b1 || paddr !== 8'hC2) $display("FAIL ws_paddr_stable got stable=%b paddr=%h exp 1/c2", stable, paddr); else n_pass++;
        pready = 4'b0000;
        tick();
    endtask

    task automatic test_timeout;
        int en_cycles = 0;
        logic got = 1'b0;
        pready = 4'b1110; pslverr = 4'b0000; prdata = 32'h0000_00C3;
        sb.push_back({1'b1, 8'h00});
        send(1'b0, 8'h10, 8'h00);
        n_checks++; if (psel !== 4'b0001) $display("FAIL to_setup got psel=%b exp=0001", psel); else n_pass++;
        for (int k = 0; k < 40 && !got; k++) begin
            tick();
            if (rsp_valid === 1'b1) got = 1'b1;
            else if (penable === 1'b1 && psel === 4'b0001) en_cycles++;
        end
        n_checks++; if (got !== 1'b1) $display("FAIL to_rsp got no response exp one within 40 cycles"); else n_pass++;
        n_checks++; if (en_cycles !== 16) $display("FAIL to_access_cycles got=%0d exp=16", en_cycles); else n_pass++;
        n_checks++; if ({psel, penable} !== 5'b0) $display("FAIL to_drop got psel=%b en=%b exp 0000/0", psel, penable); else n_pass++;
        pready = 4'b0010; prdata = 32'h0000_7700;
        sb.push_back({1'b0, 8'h77});
        send(1'b0, 8'h45, 8'h00);
        n_checks++; if (psel !== 4'b0010) $display("FAIL to_next_setup got psel=%b exp=0010", psel); else n_pass++;
        tick(); tick();
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL to_next_rsp got vld=%b exp=1", rsp_valid); else n_pass++;
        pready = 4'b0000;
        tick();
    endtask

    task automatic test_decode_miss;
        pready3 = 3'b111; pslverr3 = 3'b000; prdata3 = 24'hABCDEF;
        sb3.push_back({1'b1, 8'h00});
        r3_write = 1'b0; r3_addr = 8'hC0; r3_wdata = 8'h00; r3_valid = 1'b1;
        n_checks++; if (r3_ready !== 1'b1) $display("FAIL dm_ready got=%b exp=1", r3_ready); else n_pass++;
        tick();
        r3_valid = 1'b0;
        n_checks++; if ({psel3, penable3, s3_valid} !== 5'b0) $display("FAIL dm_t1 got psel=%b en=%b vld=%b exp 000/0/0", psel3, penable3, s3_valid); else n_pass++;
        tick();
        n_checks++; if ({s3_valid, psel3, penable3} !== 5'b1_000_0) $display("FAIL dm_t2 got vld=%b psel=%b en=%b exp 1/000/0", s3_valid, psel3, penable3); else n_pass++;
        prdata3 = 24'h3C0000;
        sb3.push_back({1'b0, 8'h3C});
        r3_addr = 8'h80; r3_valid = 1'b1;
        tick();
        r3_valid = 1'b0;
        n_checks++; if (psel3 !== 3'b100) $display("FAIL dm_valid_setup got psel=%b exp=100", psel3); else n_pass++;
        tick(); tick();
        n_checks++; if (s3_valid !== 1'b1) $display("FAIL dm_valid_rsp got vld=%b exp=1", s3_valid); else n_pass++;
        tick();
    endtask

    task automatic test_slave_error;
        pready = 4'b0100; pslverr = 4'b0100; prdata = 32'h0033_0000;
        sb.push_back({1'b1, 8'h33});
        send(1'b0, 8'h80, 8'h00);
        tick(); tick();
        n_checks++; if ({rsp_valid, psel} !== 5'b1_0000) $display("FAIL se_rsp got vld=%b psel=%b exp 1/0000", rsp_valid, psel); else n_pass++;
        tick();
        n_checks++; if ({rsp_valid, rsp_err, rsp_rdata} !== {1'b0, 1'b1, 8'h33}) $display("FAIL se_hold got vld=%b err=%b rdata=%h exp 0/1/33", rsp_valid, rsp_err, rsp_rdata); else n_pass++;
        pready = 4'b0000; pslverr = 4'b0000;
    endtask

    task automatic test_reset_mid_access;
        pready = 4'b0000; prdata = 32'h0000_9900;
        send(1'b0, 8'h45, 8'h00);
        tick(); tick();
        n_checks++; if ({psel, penable} !== 5'b0010_1) $display("FAIL rm_access got psel=%b en=%b exp 0010/1", psel, penable); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++; if ({psel, penable, rsp_valid, req_ready} !== 7'b0) $display("FAIL rm_drop got psel=%b en=%b vld=%b rdy=%b exp 0", psel, penable, rsp_valid, req_ready); else n_pass++;
        rst = 1'b0;
        pready = 4'b1111;
        tick(); tick();
        n_checks++; if ({rsp_valid, req_ready} !== 2'b01) $display("FAIL rm_no_rsp got vld=%b rdy=%b exp 0/1", rsp_valid, req_ready); else n_pass++;
    endtask

    task automatic test_back_to_back;
        pready = 4'b1111; pslverr = 4'b0000; prdata = 32'h5A00_0000;
        sb.push_back({1'b0, 8'h00});
        req_write = 1'b1; req_addr = 8'h45; req_wdata = 8'hA5; req_valid = 1'b1;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL b2b_ready0 got=%b exp=1", req_ready); else n_pass++;
        tick();
        sb.push_back({1'b0, 8'h5A});
        req_write = 1'b0; req_addr = 8'hC2; req_wdata = 8'h00;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL b2b_busy got=%b exp=0", req_ready); else n_pass++;
        tick(); tick();
        n_checks++; if ({rsp_valid, req_ready} !== 2'b11) $display("FAIL b2b_overlap got vld=%b rdy=%b exp 1/1", rsp_valid, req_ready); else n_pass++;
        tick();
        req_valid = 1'b0;
        n_checks++; if ({psel, penable, paddr} !== {4'b1000, 1'b0, 8'hC2}) $display("FAIL b2b_second_setup got psel=%b en=%b paddr=%h exp 1000/0/c2", psel, penable, paddr); else n_pass++;
        tick(); tick();
        n_checks++; if (rsp_valid !== 1'b1) $display("FAIL b2b_second_rsp got vld=%b exp=1", rsp_valid); else n_pass++;
        pready = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_zero_wait_write();
        test_wait_state_read();
        test_timeout();
        test_decode_miss();
        test_slave_error();
        test_reset_mid_access();
        test_back_to_back();
        repeat (3) tick();
        n_checks++; if (sb.size() !== 0 || sb3.size() !== 0) $display("FAIL sb_drain got pending=%0d/%0d exp 0/0", sb.size(), sb3.size()); else n_pass++;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
